ov_frame_packer: RTL and testbench

Frame packetizer between the camera-FIFO read stage and the UART transmit cache. Accepts the pixel byte stream that the read stage pulls out of the OV7670 frame FIFO and wraps each frame in a sync header, sequence number and trailer, so the host can find frame boundaries in the raw serial stream. Honours the transmit cache's full flag and back-pressures the pixel source.

---
 rtl/ov_pack_pkg.sv | 28 ++
 rtl/ov_pack_cksum.sv | 31 +++
 rtl/ov_frame_packer.sv | 195 +++++++++++++++++++
 tb/tb_ov_frame_packer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov_pack_pkg.sv
// Shared definitions for the OV7670 frame packer.
// Contents: FSM state encodings, default framing bytes, payload-size helpers.
package ov_pack_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR0    = 3'd1;
  localparam logic [2:0] ST_HDR1    = 3'd2;
  localparam logic [2:0] ST_HDR_SEQ = 3'd3;
  localparam logic [2:0] ST_PAYLOAD = 3'd4;
  localparam logic [2:0] ST_CKSUM   = 3'd5;
  localparam logic [2:0] ST_END     = 3'd6;

  localparam logic [7:0] DEF_SYNC0    = 8'hFF;
  localparam logic [7:0] DEF_SYNC1    = 8'h00;
  localparam logic [7:0] DEF_END_BYTE = 8'h55;

  // Payload bytes per frame.
  function automatic int unsigned pack_total(input int unsigned w, input int unsigned h,
                                             input int unsigned bpp);
    return w * h * bpp;
  endfunction

  // Byte counter width; never narrower than one bit.
  function automatic int unsigned pack_cnt_w(input int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/ov_pack_cksum.sv
// Running 8-bit (mod 256) sum of payload bytes for the frame trailer.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       clear the sum (takes priority over add)
//   add       accumulate data this cycle
//   data      payload byte
//   sum       current running sum
module ov_pack_cksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  logic [7:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= 8'h00;
    end else if (clr) begin
      sum_q <= 8'h00;
    end else if (add) begin
      sum_q <= sum_q + data;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/ov_frame_packer.sv
// Frame packetizer: wraps the camera pixel byte stream into
//   SYNC0 SYNC1 SEQ <payload> [CKSUM] END_BYTE
// and writes it to the UART transmit cache, honouring its full flag.
// Optional feature macro: OV_PACK_CKSUM_EN adds the 8-bit payload-sum trailer byte.
// Ports:
//   SYS_CLK, RST           clock, asynchronous active-high reset
//   FRAME_START            one-cycle pulse, new frame begins
//   PIX_DATA/VALID/READY   pixel byte source handshake
//   TX_DATA/WRREQ/WRFULL   transmit cache write port
//   FRAME_DONE, FRAME_ERR  completion / abort pulses
//   FRAME_SEQ              sequence number of current/last frame
module ov_frame_packer
  import ov_pack_pkg::*;
#(
  parameter int unsigned IMG_W    = 320,
  parameter int unsigned IMG_H    = 240,
  parameter int unsigned BPP      = 2,
  parameter logic [7:0]  SYNC0    = DEF_SYNC0,
  parameter logic [7:0]  SYNC1    = DEF_SYNC1,
  parameter logic [7:0]  END_BYTE = DEF_END_BYTE
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       FRAME_START,
  input  logic [7:0] PIX_DATA,
  input  logic       PIX_VALID,
  output logic       PIX_READY,
  output logic [7:0] TX_DATA,
  output logic       TX_WRREQ,
  input  logic       TX_WRFULL,
  output logic       FRAME_DONE,
  output logic       FRAME_ERR,
  output logic [7:0] FRAME_SEQ
);

  localparam int unsigned    TOTAL = pack_total(IMG_W, IMG_H, BPP);
  localparam int unsigned    CW    = pack_cnt_w(TOTAL);
  localparam logic [CW-1:0]  LAST  = CW'(TOTAL - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    seq_q, seq_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_wrreq_q, tx_wrreq_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ck_clr, ck_add;

`ifdef OV_PACK_CKSUM_EN
  logic [7:0] ck_sum;

  ov_pack_cksum u_cksum (
    .clk  (SYS_CLK),
    .rst  (RST),
    .clr  (ck_clr),
    .add  (ck_add),
    .data (PIX_DATA),
    .sum  (ck_sum)
  );
`else
  logic unused_ck;
  assign unused_ck = ck_clr ^ ck_add;
`endif

  assign PIX_READY = (state_q == ST_PAYLOAD) && !TX_WRFULL;

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_wrreq_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    ck_clr     = 1'b0;
    ck_add     = 1'b0;

    // A start seen while a frame is in its header/trailer is queued, not acted on.
    if (FRAME_START && (state_q != ST_IDLE) && (state_q != ST_PAYLOAD)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (FRAME_START) begin
          state_d = ST_HDR0;
          seq_d   = seq_q + 8'd1;
          ck_clr  = 1'b1;
        end
      end
      ST_HDR0: begin
        if (!TX_WRFULL) begin
          tx_data_d  = SYNC0;
          tx_wrreq_d = 1'b1;
          state_d    = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (!TX_WRFULL) begin
          tx_data_d  = SYNC1;
          tx_wrreq_d = 1'b1;
          state_d    = ST_HDR_SEQ;
        end
      end
      ST_HDR_SEQ: begin
        if (!TX_WRFULL) begin
          tx_data_d  = seq_q;
          tx_wrreq_d = 1'b1;
          state_d    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (FRAME_START) begin
          // Abort: drop any same-cycle pixel and restart with a fresh header.
          err_d     = 1'b1;
          cnt_d     = '0;
          ck_clr    = 1'b1;
          state_d   = ST_HDR0;
          seq_d     = seq_q + 8'd1;
          pending_d = 1'b0;
        end else if (PIX_VALID && !TX_WRFULL) begin
          tx_data_d  = PIX_DATA;
          tx_wrreq_d = 1'b1;
          ck_add     = 1'b1;
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef OV_PACK_CKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d = ST_END;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef OV_PACK_CKSUM_EN
      ST_CKSUM: begin
        if (!TX_WRFULL) begin
          tx_data_d  = ck_sum;
          tx_wrreq_d = 1'b1;
          state_d    = ST_END;
        end
      end
`endif
      ST_END: begin
        if (!TX_WRFULL) begin
          tx_data_d  = END_BYTE;
          tx_wrreq_d = 1'b1;
          done_d     = 1'b1;
          if (pending_q || FRAME_START) begin
            state_d   = ST_HDR0;
            seq_d     = seq_q + 8'd1;
            pending_d = 1'b0;
            ck_clr    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      seq_q      <= 8'hFF;
      pending_q  <= 1'b0;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_wrreq_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_wrreq_q <= tx_wrreq_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign TX_DATA    = tx_data_q;
  assign TX_WRREQ   = tx_wrreq_q;
  assign FRAME_DONE = done_q;
  assign FRAME_ERR  = err_q;
  assign FRAME_SEQ  = seq_q;

endmodule

// File: tb/tb_ov_frame_packer.sv
// Directed bench for ov_frame_packer with a 4x2x2 (16-byte) frame.
// Honours OV_PACK_CKSUM_EN for the expected trailer and frame length.
module tb_ov_frame_packer;

  localparam int N = 16;
`ifdef OV_PACK_CKSUM_EN
  localparam int EXP_DONE_AT = N + 6;
`else
  localparam int EXP_DONE_AT = N + 5;
`endif

  logic       SYS_CLK = 1'b0;
  logic       RST;
  logic       FRAME_START;
  logic [7:0] PIX_DATA;
  logic       PIX_VALID;
  logic       PIX_READY;
  logic [7:0] TX_DATA;
  logic       TX_WRREQ;
  logic       TX_WRFULL;
  logic       FRAME_DONE;
  logic       FRAME_ERR;
  logic [7:0] FRAME_SEQ;

  ov_frame_packer #(
    .IMG_W (4),
    .IMG_H (2),
    .BPP   (2)
  ) dut (
    .SYS_CLK     (SYS_CLK),
    .RST         (RST),
    .FRAME_START (FRAME_START),
    .PIX_DATA    (PIX_DATA),
    .PIX_VALID   (PIX_VALID),
    .PIX_READY   (PIX_READY),
    .TX_DATA     (TX_DATA),
    .TX_WRREQ    (TX_WRREQ),
    .TX_WRFULL   (TX_WRFULL),
    .FRAME_DONE  (FRAME_DONE),
    .FRAME_ERR   (FRAME_ERR),
    .FRAME_SEQ   (FRAME_SEQ)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int tests = 0;
  int fails = 0;

  logic [7:0] src [0:63];
  int src_len = 0, src_idx = 0, cyc = 0;
  int sp1 = -1, sp2 = -1, sp3 = -1, f1 = -100, f2 = -100;
  logic [7:0] txq[$];
  logic [7:0] exp_q[$];
  int done_cnt = 0, err_cnt = 0, wviol = 0, rviol = 0;
  bit last_full = 1'b0;

  // Passive monitor: records written bytes, pulses and stall violations.
  always @(negedge SYS_CLK) begin
    if (!RST) begin
      if (TX_WRREQ) txq.push_back(TX_DATA);
      if (FRAME_DONE) done_cnt++;
      if (FRAME_ERR) err_cnt++;
      if (TX_WRREQ && last_full) wviol++;
      if (TX_WRFULL && PIX_READY) rviol++;
    end
    last_full = TX_WRFULL;
  end

  task automatic drive();
    PIX_VALID   = (src_idx < src_len);
    PIX_DATA    = (src_idx < src_len) ? src[src_idx] : 8'h00;
    FRAME_START = (cyc == sp1) || (cyc == sp2) || (cyc == sp3);
    TX_WRFULL   = (cyc >= f1 && cyc < f1 + 3) || (cyc >= f2 && cyc < f2 + 3);
  endtask

  task automatic tick();
    bit xfer;
    @(negedge SYS_CLK);
    xfer = PIX_VALID && PIX_READY;
    @(posedge SYS_CLK);
    #1;
    if (xfer) src_idx++;
    cyc++;
    drive();
  endtask

  task automatic start_frame(input int first, input int len);
    src_idx = first;
    src_len = len;
    cyc     = 0;
    drive();
  endtask

  task automatic fill(input int first, input int len, input logic [7:0] base, input bit inc);
    for (int i = 0; i < len; i++) src[first + i] = inc ? base + 8'(i) : base;
  endtask

  task automatic add_exp(input logic [7:0] seq, input int first);
    logic [7:0] s;
    s = 8'h00;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(seq);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(src[first + i]);
      s = s + src[first + i];
    end
`ifdef OV_PACK_CKSUM_EN
    exp_q.push_back(s);
`endif
    exp_q.push_back(8'h55);
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok,
                           output int done_at, output int err_at);
    done_at = -1;
    err_at  = -1;
    while (done_cnt < target && cyc < budget) begin
      tick();
      if (FRAME_DONE === 1'b1 && done_at < 0) done_at = cyc;
      if (FRAME_ERR === 1'b1 && err_at < 0) err_at = cyc;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    sp1 = -1; sp2 = -1; sp3 = -1; f1 = -100; f2 = -100;
    src_len = 0; src_idx = 0; cyc = 0;
    drive();
    repeat (2) @(posedge SYS_CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    RST = 1'b1;
    #2;
    tests++; if (PIX_READY !== 1'b0) begin fails++; $display("FAIL reset PIX_READY got %b want 0", PIX_READY); end
    tests++; if (TX_DATA !== 8'h00) begin fails++; $display("FAIL reset TX_DATA got %h want 00", TX_DATA); end
    tests++; if (TX_WRREQ !== 1'b0) begin fails++; $display("FAIL reset TX_WRREQ got %b want 0", TX_WRREQ); end
    tests++; if (FRAME_DONE !== 1'b0) begin fails++; $display("FAIL reset FRAME_DONE got %b want 0", FRAME_DONE); end
    tests++; if (FRAME_ERR !== 1'b0) begin fails++; $display("FAIL reset FRAME_ERR got %b want 0", FRAME_ERR); end
    tests++; if (FRAME_SEQ !== 8'hFF) begin fails++; $display("FAIL reset FRAME_SEQ got %h want FF", FRAME_SEQ); end
    @(posedge SYS_CLK);
    #1;
    RST = 1'b0;
    // Pixels offered while idle must not be taken.
    src[0] = 8'hAA; src_len = 1; src_idx = 0; cyc = 0;
    drive();
    repeat (3) tick();
    tests++; if (PIX_READY !== 1'b0 || src_idx != 0 || TX_WRREQ !== 1'b0) begin
      fails++; $display("FAIL idle_pix ready %b idx %0d wrreq %b want 0 0 0", PIX_READY, src_idx, TX_WRREQ);
    end
  endtask

  task automatic test_basic();
    int q0, d0, e0, da, ea; bit ok;
    logic [7:0] act;
    do_reset();
    fill(0, N, 8'h01, 1'b1);
    exp_q.delete(); add_exp(8'h00, 0);
    q0 = txq.size(); d0 = done_cnt; e0 = err_cnt;
    sp1 = 0;
    start_frame(0, N);
    wait_done(d0 + 1, 80, ok, da, ea);
    repeat (3) tick();
    tests++; if (!ok) begin fails++; $display("FAIL basic timeout done %0d want %0d", done_cnt - d0, 1); end
    tests++; if (da != EXP_DONE_AT) begin fails++; $display("FAIL basic done_cycle got %0d want %0d", da, EXP_DONE_AT); end
    tests++; if (txq.size() - q0 != exp_q.size()) begin
      fails++; $display("FAIL basic length got %0d want %0d", txq.size() - q0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (q0 + i < txq.size()) ? txq[q0 + i] : 8'hxx;
      tests++; if (act !== exp_q[i]) begin fails++; $display("FAIL basic byte %0d got %h want %h", i, act, exp_q[i]); end
    end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL basic done_count got %0d want 1", done_cnt - d0); end
    tests++; if (err_cnt - e0 != 0) begin fails++; $display("FAIL basic err_count got %0d want 0", err_cnt - e0); end
    tests++; if (FRAME_SEQ !== 8'h00) begin fails++; $display("FAIL basic seq got %h want 00", FRAME_SEQ); end
  endtask

  task automatic test_stall();
    int q0, d0, w0, r0, da, ea; bit ok;
    logic [7:0] act;
    exp_q.delete(); add_exp(8'h01, 0);
    q0 = txq.size(); d0 = done_cnt; w0 = wviol; r0 = rviol;
    sp1 = 0; sp2 = -1; sp3 = -1; f1 = 2; f2 = 12;
    start_frame(0, N);
    wait_done(d0 + 1, 100, ok, da, ea);
    repeat (3) tick();
    f1 = -100; f2 = -100;
    tests++; if (!ok) begin fails++; $display("FAIL stall timeout done %0d want 1", done_cnt - d0); end
    tests++; if (da != EXP_DONE_AT + 6) begin fails++; $display("FAIL stall done_cycle got %0d want %0d", da, EXP_DONE_AT + 6); end
    tests++; if (txq.size() - q0 != exp_q.size()) begin
      fails++; $display("FAIL stall length got %0d want %0d", txq.size() - q0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (q0 + i < txq.size()) ? txq[q0 + i] : 8'hxx;
      tests++; if (act !== exp_q[i]) begin fails++; $display("FAIL stall byte %0d got %h want %h", i, act, exp_q[i]); end
    end
    tests++; if (wviol != w0) begin fails++; $display("FAIL stall wrreq_when_full got %0d want %0d", wviol, w0); end
    tests++; if (rviol != r0) begin fails++; $display("FAIL stall ready_when_full got %0d want %0d", rviol, r0); end
  endtask

  task automatic test_abort();
    int q0, d0, e0, da, ea; bit ok;
    logic [7:0] act;
    do_reset();
    fill(0, 8, 8'h01, 1'b1);
    fill(8, N, 8'h01, 1'b1);
    exp_q.delete();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'(i + 1));
    add_exp(8'h01, 8);
    q0 = txq.size(); d0 = done_cnt; e0 = err_cnt;
    sp1 = 0; sp2 = 11;
    start_frame(0, 8 + N);
    wait_done(d0 + 1, 100, ok, da, ea);
    repeat (3) tick();
    tests++; if (!ok) begin fails++; $display("FAIL abort timeout done %0d want 1", done_cnt - d0); end
    tests++; if (ea != 12) begin fails++; $display("FAIL abort err_cycle got %0d want 12", ea); end
    tests++; if (da != 11 + EXP_DONE_AT) begin fails++; $display("FAIL abort done_cycle got %0d want %0d", da, 11 + EXP_DONE_AT); end
    tests++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL abort err_count got %0d want 1", err_cnt - e0); end
    tests++; if (txq.size() - q0 != exp_q.size()) begin
      fails++; $display("FAIL abort length got %0d want %0d", txq.size() - q0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (q0 + i < txq.size()) ? txq[q0 + i] : 8'hxx;
      tests++; if (act !== exp_q[i]) begin fails++; $display("FAIL abort byte %0d got %h want %h", i, act, exp_q[i]); end
    end
    tests++; if (FRAME_SEQ !== 8'h01) begin fails++; $display("FAIL abort seq got %h want 01", FRAME_SEQ); end
  endtask

  task automatic test_pending();
    int q0, d0, da, ea; bit ok;
    logic [7:0] act;
    fill(0, N, 8'h01, 1'b1);
    fill(N, N, 8'h01, 1'b1);
    exp_q.delete(); add_exp(8'h02, 0); add_exp(8'h03, N);
    q0 = txq.size(); d0 = done_cnt;
    // Stall the trailer for three cycles and pulse start twice inside it.
    sp1 = 0; sp2 = 20; sp3 = 22; f1 = 20; f2 = -100;
    start_frame(0, 2 * N);
    wait_done(d0 + 2, 150, ok, da, ea);
    repeat (30) tick();
    sp2 = -1; sp3 = -1; f1 = -100;
    tests++; if (!ok) begin fails++; $display("FAIL pending timeout done %0d want 2", done_cnt - d0); end
    tests++; if (done_cnt - d0 != 2) begin fails++; $display("FAIL pending done_count got %0d want 2", done_cnt - d0); end
    tests++; if (txq.size() - q0 != exp_q.size()) begin
      fails++; $display("FAIL pending length got %0d want %0d", txq.size() - q0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (q0 + i < txq.size()) ? txq[q0 + i] : 8'hxx;
      tests++; if (act !== exp_q[i]) begin fails++; $display("FAIL pending byte %0d got %h want %h", i, act, exp_q[i]); end
    end
    tests++; if (FRAME_SEQ !== 8'h03) begin fails++; $display("FAIL pending seq got %h want 03", FRAME_SEQ); end
  endtask

  task automatic test_seq_wrap();
    int q0, d0, da, ea, tmo; bit ok;
    logic [7:0] act;
    do_reset();
    fill(0, N, 8'hFF, 1'b0);
    tmo = 0; q0 = 0;
    for (int f = 1; f <= 257; f++) begin
      q0 = txq.size(); d0 = done_cnt;
      sp1 = 0;
      start_frame(0, N);
      wait_done(d0 + 1, 60, ok, da, ea);
      tick();
      if (!ok) tmo++;
      if (f == 256) begin
        tests++; if (FRAME_SEQ !== 8'hFF) begin fails++; $display("FAIL wrap seq256 got %h want FF", FRAME_SEQ); end
      end
    end
    tests++; if (tmo != 0) begin fails++; $display("FAIL wrap timeouts got %0d want 0", tmo); end
    tests++; if (FRAME_SEQ !== 8'h00) begin fails++; $display("FAIL wrap seq257 got %h want 00", FRAME_SEQ); end
    exp_q.delete(); add_exp(8'h00, 0);
`ifdef OV_PACK_CKSUM_EN
    tests++; if (exp_q[N + 3] !== 8'hF0 || txq.size() < q0 + N + 4 || txq[q0 + N + 3] !== 8'hF0) begin
      fails++; $display("FAIL wrap cksum got %h want F0", (txq.size() > q0 + N + 3) ? txq[q0 + N + 3] : 8'hxx);
    end
`endif
    tests++; if (txq.size() - q0 != exp_q.size()) begin
      fails++; $display("FAIL wrap length got %0d want %0d", txq.size() - q0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (q0 + i < txq.size()) ? txq[q0 + i] : 8'hxx;
      tests++; if (act !== exp_q[i]) begin fails++; $display("FAIL wrap byte %0d got %h want %h", i, act, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int q0, d0, da, ea; bit ok;
    logic [7:0] act;
    fill(0, N, 8'h01, 1'b1);
    sp1 = 0;
    start_frame(0, N);
    repeat (8) tick();
    tests++; if (PIX_READY !== 1'b1) begin fails++; $display("FAIL rstmid pre_ready got %b want 1", PIX_READY); end
    #2;
    RST = 1'b1;
    #1;
    tests++; if (PIX_READY !== 1'b0 || TX_WRREQ !== 1'b0 || TX_DATA !== 8'h00) begin
      fails++; $display("FAIL rstmid outputs ready %b wrreq %b data %h want 0 0 00", PIX_READY, TX_WRREQ, TX_DATA);
    end
    tests++; if (FRAME_SEQ !== 8'hFF || FRAME_DONE !== 1'b0 || FRAME_ERR !== 1'b0) begin
      fails++; $display("FAIL rstmid status seq %h done %b err %b want FF 0 0", FRAME_SEQ, FRAME_DONE, FRAME_ERR);
    end
    @(posedge SYS_CLK);
    #1;
    RST = 1'b0;
    exp_q.delete(); add_exp(8'h00, 0);
    q0 = txq.size(); d0 = done_cnt;
    sp1 = 0;
    start_frame(0, N);
    wait_done(d0 + 1, 80, ok, da, ea);
    repeat (3) tick();
    tests++; if (!ok) begin fails++; $display("FAIL rstmid timeout done %0d want 1", done_cnt - d0); end
    tests++; if (txq.size() - q0 != exp_q.size()) begin
      fails++; $display("FAIL rstmid length got %0d want %0d", txq.size() - q0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (q0 + i < txq.size()) ? txq[q0 + i] : 8'hxx;
      tests++; if (act !== exp_q[i]) begin fails++; $display("FAIL rstmid byte %0d got %h want %h", i, act, exp_q[i]); end
    end
  endtask

  initial begin
    RST = 1'b1; FRAME_START = 1'b0; PIX_DATA = 8'h00; PIX_VALID = 1'b0; TX_WRFULL = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_pending();
    test_seq_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
